// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing helpers.
// The transmitter derives its bit timing from the same functions, so both
// sides of a link always agree on clocks per bit.
package uart_pkg;

    // Receiver FSM states. The encoding is fixed so the debug state output
    // reads the same in every build.
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Below this the mid-bit sample point is too coarse for reliable reception.
    localparam int MIN_CLKS_PER_BIT = 4;

    // System clocks per line bit. This is an integer division, so any
    // remainder shows up as a small, bounded baud error.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Clocks from the start-bit edge to its midpoint.
    function automatic int calc_half_bit(input int clk_freq, input int baud_rate);
        return calc_clks_per_bit(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The reset value matches the idle level of the line, so leaving reset never
// looks like a falling edge to the logic downstream.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input; only q is used downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The line is synchronized first. A falling edge in IDLE starts a frame. The
// start bit is confirmed at its midpoint, and every later bit is sampled one
// full bit period after the previous sample point.
//
// Output semantics: this is a push-only interface with no back-pressure.
// rx_valid is a one-cycle pulse. In that cycle rx_data holds a newly received
// byte, and rx_data keeps that byte until the next good frame arrives.
// rx_frame_err is a one-cycle pulse for a frame whose stop bit was sampled
// low, and it leaves rx_data untouched. The two pulses are mutually exclusive.
// dbg_state exposes the FSM state so that checkers can follow the receiver.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = calc_half_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    // Refuse to build at a clock/baud ratio too low to sample mid-bit.
    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_ratio
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    rx_state_t        state;
    rx_state_t        state_next;
    logic             rxd_s;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Strobes decoded from the current state and the bit counter.
    logic half_done;
    logic bit_done;
    logic cnt_run;
    logic sample_bit;
    logic frame_ok;
    logic frame_bad;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: frame sequencing on the synchronized line.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (!rxd_s) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is already high again at its midpoint
                // was a glitch, so the receiver drops it silently.
                if (half_done) begin
                    state_next = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_done) begin
                    state_next = rxd_s ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                // A held-low line (break) must go high before the receiver
                // re-arms, so a break reports exactly one framing error.
                if (rxd_s) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    // Output and strobe decode derived from the current state.
    always_comb begin
        half_done  = (bit_cnt == HALF_LAST);
        bit_done   = (bit_cnt == BIT_LAST);
        cnt_run    = (state == RX_START) || (state == RX_DATA) || (state == RX_STOP);
        sample_bit = (state == RX_DATA) && bit_done;
        frame_ok   = (state == RX_STOP) && bit_done && rxd_s;
        frame_bad  = (state == RX_STOP) && bit_done && !rxd_s;
        rx_busy    = (state != RX_IDLE);
        dbg_state  = state;
    end

    // Bit-period counter. It restarts on every state change and after each
    // data sample, and it stops at its terminal value instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if ((state_next != state) || sample_bit) begin
            bit_cnt <= '0;
        end else if (cnt_run && !bit_done) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Data bit index. It is cleared while the start bit is checked and
    // advances on each data sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx <= 3'd0;
        end else if (state == RX_START) begin
            bit_idx <= 3'd0;
        end else if (sample_bit) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Assemble the byte LSB first by writing each sample to its own position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= 8'h00;
        end else if (sample_bit) begin
            shift_reg[bit_idx] <= rxd_s;
        end
    end

    // Result registers: publish the byte and raise the pulses in the cycle
    // after the stop-bit sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= frame_ok;
            rx_frame_err <= frame_bad;
            if (frame_ok) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = 10;
    localparam int HALF      = 5;
    localparam int LAT       = 2 + HALF + 9 * CPB + 1;  // 98 cycles

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    int valid_cnt      = 0;
    int ferr_cnt       = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;

    always @(negedge clk) begin
        if (rx_valid || rx_frame_err)
            check_eq("valid_ferr_exclusive", {31'd0, rx_valid & rx_frame_err}, 32'd0);
        if (rx_valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            check_eq("sb_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check_eq("sb_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (rx_frame_err) ferr_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (CPB) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int v0;
        int f0;
        int t0;
        int lat;
        logic [7:0] d;

        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) tick();
        check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("rst_state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        repeat (5) tick();

        // Single byte 0xA5 with a good stop bit
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        repeat (5) tick();
        lat = last_valid_cyc - t0;
        check_eq("a5_valid_count", valid_cnt - v0, 32'd1);
        check_eq("a5_no_ferr", ferr_cnt - f0, 32'd0);
        check_eq("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check_eq("a5_busy_low", {31'd0, rx_busy}, 32'd0);
        check_eq("a5_latency_98pm1", {31'd0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 32'd1);

        // Back-to-back 0x00 then 0xFF with no idle gap between frames
        v0 = valid_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (5) tick();
        check_eq("b2b_valid_count", valid_cnt - v0, 32'd2);
        check_eq("b2b_spacing", last_valid_cyc - prev_valid_cyc, 32'd100);
        check_eq("b2b_rx_data", {24'd0, rx_data}, 32'hFF);

        // A 3-cycle low glitch on the idle line
        v0 = valid_cnt; f0 = ferr_cnt;
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        check_eq("glitch_start_seen", {31'd0, rx_busy}, 32'd1);
        repeat (HALF + 3) tick();
        check_eq("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        check_eq("glitch_state_idle", {29'd0, dbg_state}, 32'd0);
        repeat (20) tick();
        check_eq("glitch_no_valid", valid_cnt - v0, 32'd0);
        check_eq("glitch_no_ferr", ferr_cnt - f0, 32'd0);

        // Framing error: 0x3C with stop bit 0, then the line held low (break)
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (50) tick();
        check_eq("break_wait_idle", {29'd0, dbg_state}, 32'd4);
        check_eq("break_busy", {31'd0, rx_busy}, 32'd1);
        uart_rxd = 1'b1;
        repeat (CPB) tick();
        check_eq("ferr_count", ferr_cnt - f0, 32'd1);
        check_eq("ferr_no_valid", valid_cnt - v0, 32'd0);
        check_eq("ferr_data_kept", {24'd0, rx_data}, 32'hFF);
        check_eq("ferr_back_idle", {29'd0, dbg_state}, 32'd0);
        v0 = valid_cnt;
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        repeat (5) tick();
        check_eq("after_ferr_valid", valid_cnt - v0, 32'd1);
        check_eq("after_ferr_data", {24'd0, rx_data}, 32'h81);

        // Reset asserted in the middle of data bit 4 of 0x5A
        v0 = valid_cnt; f0 = ferr_cnt;
        d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        uart_rxd = d[4];
        repeat (HALF) tick();
        reset = 1'b1;
        #1;
        check_eq("midrst_rx_data", {24'd0, rx_data}, 32'h00);
        check_eq("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("midrst_ferr", {31'd0, rx_frame_err}, 32'd0);
        check_eq("midrst_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("midrst_state", {29'd0, dbg_state}, 32'd0);
        repeat (CPB - HALF) tick();
        for (int i = 5; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        reset = 1'b0;
        repeat (20) tick();
        check_eq("midrst_no_valid", valid_cnt - v0, 32'd0);
        check_eq("midrst_no_ferr", ferr_cnt - f0, 32'd0);
        check_eq("midrst_data_held", {24'd0, rx_data}, 32'h00);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        repeat (5) tick();
        check_eq("after_rst_valid", valid_cnt - v0, 32'd1);
        check_eq("after_rst_data", {24'd0, rx_data}, 32'hC3);

        // ---------------- final report ----------------
        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
